// File: rtl/lap_timer_if.sv
// lap_timer_if: control inputs and time/lap status outputs of the lap timer.
interface lap_timer_if #(
  parameter int unsigned LAP_DEPTH = 4
);
  localparam int unsigned CW = $clog2(LAP_DEPTH) + 1;

  logic          start;
  logic          clear;
  logic          mode;
  logic          load;
  logic [5:0]    preset_h;
  logic [5:0]    preset_m;
  logic [5:0]    preset_s;
  logic          lap;
  logic          lap_rd;

  logic [5:0]    hours;
  logic [5:0]    minutes;
  logic [5:0]    seconds;
  logic [6:0]    subsec;
  logic          running;
  logic          expired;
  logic          lap_valid;
  logic          lap_full;
  logic          lap_ovf;
  logic [CW-1:0] lap_count;
  logic [5:0]    lap_h;
  logic [5:0]    lap_m;
  logic [5:0]    lap_s;
  logic [6:0]    lap_sub;

  modport master (
    output start, clear, mode, load, preset_h, preset_m, preset_s, lap, lap_rd,
    input  hours, minutes, seconds, subsec, running, expired,
    input  lap_valid, lap_full, lap_ovf, lap_count, lap_h, lap_m, lap_s, lap_sub
  );

  modport slave (
    input  start, clear, mode, load, preset_h, preset_m, preset_s, lap, lap_rd,
    output hours, minutes, seconds, subsec, running, expired,
    output lap_valid, lap_full, lap_ovf, lap_count, lap_h, lap_m, lap_s, lap_sub
  );
endinterface

// File: rtl/lap_timer.sv
// lap_timer: h:m:s:sub stopwatch with tick prescaler, countdown with expiry,
// and a lap-capture FIFO whose head is presented as registered read data.
module lap_timer #(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned SUB_MAX   = 100,
  parameter int unsigned HOUR_MAX  = 24,
  parameter int unsigned LAP_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  lap_timer_if.slave bus
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = $clog2(LAP_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = 25;

  localparam logic [0:0] ST_STOPPED = 1'b0;
  localparam logic [0:0] ST_RUNNING = 1'b1;

  // Run/stop state and time registers
  logic [0:0]    state_q, state_nxt;
  logic [PW-1:0] presc_q, presc_nxt;
  logic [5:0]    hr_q, hr_nxt, mn_q, mn_nxt, sc_q, sc_nxt;
  logic [6:0]    sub_q, sub_nxt;
  logic          exp_q, exp_nxt;
  logic          mode_q, mode_nxt;

  // Edge detectors; the arm bits keep an input held through reset from acting
  logic          start_q, start_p, start_arm;
  logic          lap_q, lap_p, lap_arm;
  logic          start_edge_c, lap_edge_c;

  // Candidate next times for one tick in each direction
  logic [5:0]    up_h, up_m, up_s, dn_h, dn_m, dn_s;
  logic [6:0]    up_sub, dn_sub;
  logic          dn_zero_c;
  logic          tick_c, time_zero_c, load_c;

  // Lap FIFO
  logic [LW-1:0] mem [LAP_DEPTH];
  logic [AW-1:0] rd_q, rd_nxt, wr_q, wr_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [LW-1:0] head_q, head_nxt, wdata_c;
  logic          valid_q, full_q, ovf_q, ovf_nxt;
  logic          pop_c, do_wr_c, fifo_full_c;

  function automatic logic [5:0] sat59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  // Sample start/lap and detect first-high sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q   <= 1'b0;
      start_p   <= 1'b0;
      start_arm <= 1'b0;
      lap_q     <= 1'b0;
      lap_p     <= 1'b0;
      lap_arm   <= 1'b0;
    end else begin
      start_q   <= bus.start;
      start_p   <= start_q;
      start_arm <= start_arm | ~bus.start;
      lap_q     <= bus.lap;
      lap_p     <= lap_q;
      lap_arm   <= lap_arm | ~bus.lap;
    end
  end

  assign start_edge_c = start_q & ~start_p & start_arm;
  assign lap_edge_c   = lap_q & ~lap_p & lap_arm;

  // Up-count candidate with cascaded carries
  always_comb begin
    up_h   = hr_q;
    up_m   = mn_q;
    up_s   = sc_q;
    up_sub = sub_q + 7'd1;
    if (sub_q >= 7'(SUB_MAX - 1)) begin
      up_sub = '0;
      up_s   = sc_q + 6'd1;
      if (sc_q >= 6'd59) begin
        up_s = '0;
        up_m = mn_q + 6'd1;
        if (mn_q >= 6'd59) begin
          up_m = '0;
          up_h = (hr_q >= 6'(HOUR_MAX - 1)) ? 6'd0 : hr_q + 6'd1;
        end
      end
    end
  end

  // Down-count candidate with cascaded borrows
  always_comb begin
    dn_h   = hr_q;
    dn_m   = mn_q;
    dn_s   = sc_q;
    dn_sub = sub_q - 7'd1;
    if (sub_q == 7'd0) begin
      dn_sub = 7'(SUB_MAX - 1);
      dn_s   = sc_q - 6'd1;
      if (sc_q == 6'd0) begin
        dn_s = 6'd59;
        dn_m = mn_q - 6'd1;
        if (mn_q == 6'd0) begin
          dn_m = 6'd59;
          dn_h = hr_q - 6'd1;
        end
      end
    end
    dn_zero_c = (dn_h == 6'd0) && (dn_m == 6'd0) && (dn_s == 6'd0) && (dn_sub == 7'd0);
  end

  assign tick_c      = (state_q == ST_RUNNING) && (presc_q == PW'(TICK_DIV - 1));
  assign time_zero_c = (hr_q == 6'd0) && (mn_q == 6'd0) && (sc_q == 6'd0) && (sub_q == 7'd0);
  assign load_c      = (state_q == ST_STOPPED) && bus.mode && bus.load;

  // Next state and time: clear > load > start > tick
  always_comb begin
    state_nxt = state_q;
    presc_nxt = presc_q;
    hr_nxt    = hr_q;
    mn_nxt    = mn_q;
    sc_nxt    = sc_q;
    sub_nxt   = sub_q;
    exp_nxt   = exp_q;
    mode_nxt  = (state_q == ST_STOPPED) ? bus.mode : mode_q;

    if (state_q == ST_RUNNING) begin
      presc_nxt = tick_c ? '0 : presc_q + PW'(1);
    end

    if (bus.clear) begin
      hr_nxt    = '0;
      mn_nxt    = '0;
      sc_nxt    = '0;
      sub_nxt   = '0;
      exp_nxt   = 1'b0;
      state_nxt = ST_STOPPED;
    end else if (load_c) begin
      hr_nxt  = sat59(bus.preset_h);
      mn_nxt  = sat59(bus.preset_m);
      sc_nxt  = sat59(bus.preset_s);
      sub_nxt = '0;
      exp_nxt = 1'b0;
    end else if (start_edge_c) begin
      if (state_q == ST_RUNNING) begin
        state_nxt = ST_STOPPED;
      end else if (!(bus.mode && time_zero_c)) begin
        state_nxt = ST_RUNNING;
        presc_nxt = '0;
        exp_nxt   = 1'b0;
      end
    end else if (tick_c) begin
      if (!mode_q) begin
        hr_nxt  = up_h;
        mn_nxt  = up_m;
        sc_nxt  = up_s;
        sub_nxt = up_sub;
      end else begin
        hr_nxt  = dn_h;
        mn_nxt  = dn_m;
        sc_nxt  = dn_s;
        sub_nxt = dn_sub;
        if (dn_zero_c) begin
          exp_nxt   = 1'b1;
          state_nxt = ST_STOPPED;
        end
      end
    end
  end

  // State and time registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STOPPED;
      presc_q <= '0;
      hr_q    <= '0;
      mn_q    <= '0;
      sc_q    <= '0;
      sub_q   <= '0;
      exp_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      presc_q <= presc_nxt;
      hr_q    <= hr_nxt;
      mn_q    <= mn_nxt;
      sc_q    <= sc_nxt;
      sub_q   <= sub_nxt;
      exp_q   <= exp_nxt;
      mode_q  <= mode_nxt;
    end
  end

  // FIFO pointers, occupancy and next head; a pop frees room for a same-cycle write
  always_comb begin
    wdata_c     = {hr_q, mn_q, sc_q, sub_q};
    fifo_full_c = (cnt_q == CW'(LAP_DEPTH));
    pop_c       = bus.lap_rd && (cnt_q != '0);
    do_wr_c     = lap_edge_c && (!fifo_full_c || pop_c);
    ovf_nxt     = ovf_q | (lap_edge_c && fifo_full_c && !pop_c);
    rd_nxt      = pop_c ? rd_q + AW'(1) : rd_q;
    wr_nxt      = do_wr_c ? wr_q + AW'(1) : wr_q;
    cnt_nxt     = cnt_q;
    if (do_wr_c && !pop_c) begin
      cnt_nxt = cnt_q + CW'(1);
    end else if (!do_wr_c && pop_c) begin
      cnt_nxt = cnt_q - CW'(1);
    end
    head_nxt = head_q;
    if (cnt_nxt != '0) begin
      head_nxt = (do_wr_c && (rd_nxt == wr_q)) ? wdata_c : mem[rd_nxt];
    end
  end

  // FIFO control and head registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rd_q    <= rd_nxt;
      wr_q    <= wr_nxt;
      cnt_q   <= cnt_nxt;
      head_q  <= head_nxt;
      valid_q <= (cnt_nxt != '0);
      full_q  <= (cnt_nxt == CW'(LAP_DEPTH));
      ovf_q   <= ovf_nxt;
    end
  end

  // Lap storage array
  always_ff @(posedge clk) begin
    if (do_wr_c) begin
      mem[wr_q] <= wdata_c;
    end
  end

  assign bus.hours     = hr_q;
  assign bus.minutes   = mn_q;
  assign bus.seconds   = sc_q;
  assign bus.subsec    = sub_q;
  assign bus.running   = state_q[0];
  assign bus.expired   = exp_q;
  assign bus.lap_valid = valid_q;
  assign bus.lap_full  = full_q;
  assign bus.lap_ovf   = ovf_q;
  assign bus.lap_count = cnt_q;
  assign bus.lap_h     = head_q[24:19];
  assign bus.lap_m     = head_q[18:13];
  assign bus.lap_s     = head_q[12:7];
  assign bus.lap_sub   = head_q[6:0];
endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: directed scenarios plus random control traffic, checked every
// cycle against a model that keeps time as one sub-second total.
module tb_lap_timer;
  localparam int unsigned TICK_DIV  = 2;
  localparam int unsigned SUB_MAX   = 100;
  localparam int unsigned HOUR_MAX  = 24;
  localparam int unsigned LAP_DEPTH = 4;
  localparam int unsigned SEC_T = SUB_MAX;
  localparam int unsigned MIN_T = 60 * SUB_MAX;
  localparam int unsigned HR_T  = 3600 * SUB_MAX;
  localparam int unsigned DAY_T = HOUR_MAX * HR_T;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lap_timer_if #(.LAP_DEPTH(LAP_DEPTH)) bus ();

  lap_timer #(
    .TICK_DIV (TICK_DIV),
    .SUB_MAX  (SUB_MAX),
    .HOUR_MAX (HOUR_MAX),
    .LAP_DEPTH(LAP_DEPTH)
  ) u_dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  bit          m_run, m_exp, m_ovf, m_mode_lat;
  int unsigned m_total, m_since;
  int unsigned m_laps[$];
  bit          m_st1, m_st2, m_lp1, m_lp2;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp_v);
    end
  endtask

  function automatic int unsigned sat59(input int unsigned v);
    return (v > 59) ? 59 : v;
  endfunction

  // Samples taken before the first edge after reset count as high, so a held input never acts
  task automatic model_reset();
    m_run = 0; m_exp = 0; m_ovf = 0; m_mode_lat = 0;
    m_total = 0; m_since = 0;
    m_laps.delete();
    m_st1 = 1; m_st2 = 1; m_lp1 = 1; m_lp2 = 1;
  endtask

  task automatic model_edge();
    bit st_edge, lp_edge, tick, pop;
    int unsigned since_now;
    st_edge   = m_st1 && !m_st2;
    lp_edge   = m_lp1 && !m_lp2;
    since_now = m_since + 1;
    tick      = m_run && ((since_now % TICK_DIV) == 0);

    pop = bus.lap_rd && (m_laps.size() > 0);
    if (lp_edge && (m_laps.size() == LAP_DEPTH) && !pop) begin
      m_ovf = 1;
    end else begin
      if (pop) void'(m_laps.pop_front());
      if (lp_edge) m_laps.push_back(m_total);
    end

    if (m_run) m_since = since_now;
    if (bus.clear) begin
      m_total = 0; m_exp = 0; m_run = 0;
    end else if (!m_run && bus.mode && bus.load) begin
      m_total = sat59(bus.preset_h) * HR_T + sat59(bus.preset_m) * MIN_T + sat59(bus.preset_s) * SEC_T;
      m_exp = 0;
    end else if (st_edge) begin
      if (m_run) begin
        m_run = 0;
      end else if (!(bus.mode && m_total == 0)) begin
        m_run = 1; m_since = 0; m_exp = 0; m_mode_lat = bus.mode;
      end
    end else if (tick) begin
      if (!m_mode_lat) begin
        m_total = (m_total + 1) % DAY_T;
      end else begin
        m_total = m_total - 1;
        if (m_total == 0) begin
          m_exp = 1; m_run = 0;
        end
      end
    end

    m_st2 = m_st1; m_st1 = bus.start;
    m_lp2 = m_lp1; m_lp1 = bus.lap;
  endtask

  task automatic compare_all();
    int unsigned hd;
    check("hours",     bus.hours,     m_total / HR_T);
    check("minutes",   bus.minutes,   (m_total / MIN_T) % 60);
    check("seconds",   bus.seconds,   (m_total / SEC_T) % 60);
    check("subsec",    bus.subsec,    m_total % SUB_MAX);
    check("running",   bus.running,   m_run);
    check("expired",   bus.expired,   m_exp);
    check("lap_valid", bus.lap_valid, m_laps.size() > 0);
    check("lap_full",  bus.lap_full,  m_laps.size() == LAP_DEPTH);
    check("lap_ovf",   bus.lap_ovf,   m_ovf);
    check("lap_count", bus.lap_count, m_laps.size());
    if (m_laps.size() > 0) begin
      hd = m_laps[0];
      check("lap_h",   bus.lap_h,   hd / HR_T);
      check("lap_m",   bus.lap_m,   (hd / MIN_T) % 60);
      check("lap_s",   bus.lap_s,   (hd / SEC_T) % 60);
      check("lap_sub", bus.lap_sub, hd % SUB_MAX);
    end
  endtask

  // One clock: model follows the DUT edge, outputs compared 1 time unit later
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; run(2);
    bus.start = 1'b0; run(1);
  endtask

  task automatic do_load(input int unsigned h, input int unsigned m, input int unsigned s);
    bus.mode = 1'b1; bus.preset_h = 6'(h); bus.preset_m = 6'(m); bus.preset_s = 6'(s);
    bus.load = 1'b1; run(1);
    bus.load = 1'b0; run(1);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; run(1);
    bus.clear = 1'b0; run(1);
  endtask

  task automatic lap_pulse();
    bus.lap = 1'b1; run(1);
    bus.lap = 1'b0; run(6);
  endtask

  initial begin
    bus.start = 1'b0; bus.clear = 1'b0; bus.mode = 1'b0; bus.load = 1'b0;
    bus.preset_h = '0; bus.preset_m = '0; bus.preset_s = '0;
    bus.lap = 1'b0; bus.lap_rd = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    run(3);

    // Up count, then stop and stay frozen
    pulse_start();
    run(205);
    pulse_start();
    run(50);
    check("t1_stopped", bus.running, 0);

    // Hour rollover continues running
    do_load(23, 59, 59);
    bus.mode = 1'b0;
    run(1);
    pulse_start();
    run(215);
    check("t2_wrap_running", bus.running, 1);
    check("t2_wrap_hours", bus.hours, 0);
    pulse_start();

    // Preset saturation
    do_clear();
    do_load(63, 60, 59);
    check("sat_h", bus.hours, 59);
    check("sat_m", bus.minutes, 59);
    check("sat_s", bus.seconds, 59);
    do_clear();

    // Countdown to expiry, restart at zero ignored, clear drops expired
    do_load(0, 0, 1);
    pulse_start();
    run(210);
    check("t3_expired", bus.expired, 1);
    check("t3_stopped", bus.running, 0);
    pulse_start();
    run(5);
    check("t3_restart_ignored", bus.running, 0);
    do_clear();
    check("t3_clear_exp", bus.expired, 0);

    // clear and start edge in the same cycle while running
    bus.mode = 1'b0;
    pulse_start();
    run(20);
    bus.start = 1'b1; run(1);
    bus.clear = 1'b1; run(1);
    bus.clear = 1'b0; bus.start = 1'b0; run(3);
    check("t6_stopped", bus.running, 0);
    check("t6_subsec", bus.subsec, 0);

    // Async reset between edges, start held across release
    pulse_start();
    run(30);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_lap_h", bus.lap_h, 0);
    check("rst_lap_sub", bus.lap_sub, 0);
    bus.start = 1'b1;
    run(2);
    rst_n = 1'b1;
    run(10);
    check("t5_held_start", bus.running, 0);
    bus.start = 1'b0; run(2);
    bus.start = 1'b1; run(2);
    bus.start = 1'b0; run(5);
    check("t5_rearmed", bus.running, 1);

    // Lap FIFO fill, write+pop when full, overflow, drain in order
    repeat (4) lap_pulse();
    check("t4_full", bus.lap_full, 1);
    bus.lap = 1'b1; run(1);
    bus.lap = 1'b0; bus.lap_rd = 1'b1; run(1);
    bus.lap_rd = 1'b0; run(2);
    check("t4_wr_pop_count", bus.lap_count, 4);
    check("t4_wr_pop_no_ovf", bus.lap_ovf, 0);
    lap_pulse();
    check("t4_ovf", bus.lap_ovf, 1);
    bus.lap_rd = 1'b1; run(4);
    bus.lap_rd = 1'b0; run(1);
    check("t4_drained", bus.lap_valid, 0);
    bus.lap_rd = 1'b1; run(2);
    bus.lap_rd = 1'b0; run(1);
    pulse_start();

    // Random control traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) bus.start = ~bus.start;
      bus.clear  = ($urandom_range(0, 299) == 0);
      bus.load   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) bus.mode = ~bus.mode;
      bus.lap    = ($urandom_range(0, 7) == 0);
      bus.lap_rd = ($urandom_range(0, 5) == 0);
      if (bus.load) begin
        if ($urandom_range(0, 1) == 0) begin
          bus.preset_h = '0; bus.preset_m = '0;
          bus.preset_s = 6'($urandom_range(0, 3));
        end else begin
          bus.preset_h = 6'($urandom_range(0, 23));
          bus.preset_m = 6'($urandom_range(0, 63));
          bus.preset_s = 6'($urandom_range(0, 63));
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
